tmu_scangen: RTL and testbench
==============================

# tmu_scangen

Point-scan sequencer for the texture-mapping unit: on a start pulse it latches a destination rectangle and affine texture-coordinate gradients, then walks the rectangle in raster order. It emits one (X, Y, U, V) point per accepted handshake into the filter stage. It waits for the downstream pipeline to drain before reporting done. It sits at the head of the TMU pipeline and is the only producer for the filter stage.

## Interface
Parameters:
- FRAC, 6, fractional bits of the internal U/V accumulators (accumulator width 11+FRAC)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle go; sampled only in IDLE
- abort  in  1  stop issuing points, drain, finish
- busy  out  1  high whenever state != IDLE
- done  out  1  single-cycle pulse on the DRAIN -> IDLE transition
- x0, y0  in  11 each  destination origin
- width, height  in  11 each  rectangle size in points (0 allowed)
- u0, v0  in  11 each  texture coordinate at (x0, y0), integer
- du_dx, dv_dx, du_dy, dv_dy  in  11+FRAC each  signed two's-complement gradients, 11.FRAC format
- pipe_stb_o  out  1  point valid
- pipe_ack_i  in  1  downstream accepts (may be combinational from stb)
- P_X, P_Y, P_U, P_V  out  11 each  current point
- down_busy  in  1  OR of downstream stage busy flags

## Operation
- All config inputs are latched on the accepted start and ignored afterwards.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start when width != 0 and height != 0; IDLE -> DRAIN on start when either is 0, with no points emitted.
- RUN: pipe_stb_o = 1; a transfer is stb & ack. On each transfer advance i (column); when i = width-1, set i = 0 and advance j (row). The transfer of point (width-1, height-1) moves to DRAIN.
- abort in RUN: the current cycle's transfer completes if acked; no further points; go to DRAIN. abort in IDLE or DRAIN has no effect.
- DRAIN: pipe_stb_o = 0; wait until down_busy = 0 (evaluated from the cycle after entry), then pulse done and return to IDLE.
- Arithmetic:
  - P_X = (x0 + i) mod 2048 and P_Y = (y0 + j) mod 2048.
  - Row-start accumulators ur, vr init {u0, FRAC'b0}, {v0, FRAC'b0}; they add du_dy/dv_dy per row.
  - Point accumulators u, v reload from the updated row start at each row change; otherwise they add du_dx/dv_dx per transfer.
  - All accumulators wrap mod 2^(11+FRAC); no saturation.
  - P_U = u[10+FRAC:FRAC] and P_V = v[10+FRAC:FRAC], i.e. truncation.
- Outputs are held stable while stb=1 and ack=0.
- start while busy is ignored.

## Timing
- Reset (async assert, sync-released use): state IDLE, pipe_stb_o 0, busy 0, done 0, and P_X/P_Y/P_U/P_V 0.
- Start accepted at edge n: busy and pipe_stb_o are high from cycle n+1, with point (0,0) presented.
- Throughput is one point per cycle with ack held high; width*height points take width*height cycles in RUN.
- The last transfer at edge m puts the block in DRAIN at m+1. With down_busy low, done pulses in cycle m+2 and busy falls at m+3.
- Registered outputs only; no combinational path from pipe_ack_i to pipe_stb_o.

## Structure
- The shared tmu package holds the 11-bit coordinate width constant, the FRAC default, and the state encoding (IDLE=0, RUN=1, DRAIN=2).
- One natural sub-module, tmu_scangen_dda: the row/point U/V accumulator pair instantiated twice (U, V). Its inputs are the init value, the two gradients, and step/newrow strobes. The counters and FSM stay in the top.

## Test plan
- width=3, height=2, x0=10, y0=20, u0=5, v0=7, all gradients +1.0 (64), ack always 1 -> 6 points in order X=10,11,12,10,11,12 with Y=20,20,20,21,21,21. U=5,6,7,6,7,8 and V likewise offset by 2. done pulses 2 cycles after the last transfer.
- Same config with ack toggling 1,0,1,0 -> identical point sequence; outputs are stable during every ack=0 cycle.
- width=0, height=5, start -> no stb; busy high for 2 cycles and done pulses once.
- du_dx = -0.5 (-32), u0=0, width=4, height=1 -> P_U = 0, 2047, 2047, 2046, showing wrap and truncation.
- abort asserted after 2 transfers of a 4x4 job, with down_busy held high 5 cycles -> no further stb; done pulses only after down_busy falls.
- sys_rst_n pulled low mid-RUN -> pipe_stb_o, busy and done are 0 immediately (asynchronously). After release, a start begins a fresh job from point (0,0).

Source files
------------

// File: rtl/tmu_scangen_pkg.sv
// Shared definitions for the TMU point-scan sequencer.
//   COORD_W      : width of screen and texture coordinates (11 bits)
//   FRAC_DEFAULT : default fractional bits of the U/V accumulators
//   scan_state_e : sequencer state encoding (IDLE=0, RUN=1, DRAIN=2)
package tmu_scangen_pkg;

  localparam int COORD_W      = 11;
  localparam int FRAC_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/tmu_scangen_dda.sv
// Row/point accumulator pair for one texture coordinate (U or V).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : latch gradients and initialise both accumulators from init_i
//   init_i        : integer coordinate at the rectangle origin
//   dx_i, dy_i    : signed 11.FRAC gradients per column / per row
//   step_i        : advance one column (add dx)
//   newrow_i      : advance one row (row start += dy, point reloads from it)
//   coord_o       : integer part of the point accumulator (truncated)
module tmu_scangen_dda
  import tmu_scangen_pkg::*;
#(
  parameter int FRAC = FRAC_DEFAULT,
  localparam int AW  = COORD_W + FRAC
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [COORD_W-1:0] init_i,
  input  logic [AW-1:0]      dx_i,
  input  logic [AW-1:0]      dy_i,
  input  logic               step_i,
  input  logic               newrow_i,
  output logic [COORD_W-1:0] coord_o
);

  logic [AW-1:0] dx_q, dx_d;
  logic [AW-1:0] dy_q, dy_d;
  logic [AW-1:0] ur_q, ur_d;   // accumulator at the start of the current row
  logic [AW-1:0] u_q, u_d;     // accumulator at the current point

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    ur_d = ur_q;
    u_d  = u_q;
    if (load_i) begin
      dx_d = dx_i;
      dy_d = dy_i;
      ur_d = {init_i, {FRAC{1'b0}}};
      u_d  = {init_i, {FRAC{1'b0}}};
    end else if (newrow_i) begin
      // Point reloads from the already-advanced row start.
      ur_d = ur_q + dy_q;
      u_d  = ur_q + dy_q;
    end else if (step_i) begin
      u_d  = u_q + dx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dx_q <= '0;
      dy_q <= '0;
      ur_q <= '0;
      u_q  <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
      ur_q <= ur_d;
      u_q  <= u_d;
    end
  end

  // Integer part only: fractional bits are dropped (truncation, wraps naturally).
  assign coord_o = u_q[AW-1:FRAC];

endmodule

// File: rtl/tmu_scangen.sv
// Point-scan sequencer at the head of the TMU pipeline. On start it latches a
// destination rectangle and affine U/V gradients, then emits one (X,Y,U,V)
// point per accepted handshake in raster order, and finally waits for the
// downstream stages to go idle before pulsing done.
// Ports:
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   start, abort              : job go (IDLE only) / early stop (RUN only)
//   busy, done                : state != IDLE / one-cycle completion pulse
//   x0,y0,width,height        : destination rectangle
//   u0,v0                     : integer texture coordinate at (x0,y0)
//   du_dx,dv_dx,du_dy,dv_dy   : signed 11.FRAC gradients
//   pipe_stb_o, pipe_ack_i    : point handshake to the filter stage
//   P_X,P_Y,P_U,P_V           : current point
//   down_busy                 : downstream pipeline still has work in flight
module tmu_scangen
  import tmu_scangen_pkg::*;
#(
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  input  logic [COORD_W-1:0]       x0,
  input  logic [COORD_W-1:0]       y0,
  input  logic [COORD_W-1:0]       width,
  input  logic [COORD_W-1:0]       height,
  input  logic [COORD_W-1:0]       u0,
  input  logic [COORD_W-1:0]       v0,
  input  logic [COORD_W+FRAC-1:0]  du_dx,
  input  logic [COORD_W+FRAC-1:0]  dv_dx,
  input  logic [COORD_W+FRAC-1:0]  du_dy,
  input  logic [COORD_W+FRAC-1:0]  dv_dy,
  output logic                     pipe_stb_o,
  input  logic                     pipe_ack_i,
  output logic [COORD_W-1:0]       P_X,
  output logic [COORD_W-1:0]       P_Y,
  output logic [COORD_W-1:0]       P_U,
  output logic [COORD_W-1:0]       P_V,
  input  logic                     down_busy
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  scan_state_e        state_q;
  logic               stb_q, busy_q, done_q;
  logic [COORD_W-1:0] x0_q, w_q, h_q;
  logic [COORD_W-1:0] i_q, j_q;     // column / row index of the presented point
  logic [COORD_W-1:0] px_q, py_q;   // screen position, kept incrementally

  logic load, xfer, last_col, last_row, last_pt, step, newrow;

  assign load     = (state_q == IDLE) && start;
  assign xfer     = stb_q && pipe_ack_i;
  assign last_col = (i_q == w_q - ONE);
  assign last_row = (j_q == h_q - ONE);
  assign last_pt  = last_col && last_row;
  // Nothing advances past the final point so outputs stay put in DRAIN.
  assign step     = xfer && !last_col;
  assign newrow   = xfer && last_col && !last_row;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x0_q   <= x0;
            w_q    <= width;
            h_q    <= height;
            i_q    <= '0;
            j_q    <= '0;
            px_q   <= x0;
            py_q   <= y0;
            busy_q <= 1'b1;
            if ((width != '0) && (height != '0)) begin
              state_q <= RUN;
              stb_q   <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        RUN: begin
          if (xfer && !last_pt) begin
            if (last_col) begin
              i_q  <= '0;
              j_q  <= j_q + ONE;
              px_q <= x0_q;
              py_q <= py_q + ONE;
            end else begin
              i_q  <= i_q + ONE;
              px_q <= px_q + ONE;
            end
          end
          // A transfer in the abort cycle still counts; nothing is offered after it.
          if (abort || (xfer && last_pt)) begin
            state_q <= DRAIN;
            stb_q   <= 1'b0;
          end
        end
        DRAIN: begin
          // done is raised while still in DRAIN so it coincides with the last
          // busy cycle; the following edge returns to IDLE.
          if (done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!down_busy) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  tmu_scangen_dda #(.FRAC(FRAC)) u_dda_u (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .load_i   (load),
    .init_i   (u0),
    .dx_i     (du_dx),
    .dy_i     (du_dy),
    .step_i   (step),
    .newrow_i (newrow),
    .coord_o  (P_U)
  );

  tmu_scangen_dda #(.FRAC(FRAC)) u_dda_v (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .load_i   (load),
    .init_i   (v0),
    .dx_i     (dv_dx),
    .dy_i     (dv_dy),
    .step_i   (step),
    .newrow_i (newrow),
    .coord_o  (P_V)
  );

  assign pipe_stb_o = stb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign P_X        = px_q;
  assign P_Y        = py_q;

endmodule

// File: tb/tb_tmu_scangen.sv
module tb_tmu_scangen;

  localparam int F  = 6;
  localparam int AW = 11 + F;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [10:0]   x0 = '0, y0 = '0, width = '0, height = '0, u0 = '0, v0 = '0;
  logic [AW-1:0] du_dx = '0, dv_dx = '0, du_dy = '0, dv_dy = '0;
  logic          pipe_stb_o;
  logic          pipe_ack_i = 1'b0;
  logic [10:0]   P_X, P_Y, P_U, P_V;
  logic          down_busy = 1'b0;

  tmu_scangen #(.FRAC(F)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .u0         (u0),
    .v0         (v0),
    .du_dx      (du_dx),
    .dv_dx      (dv_dx),
    .du_dy      (du_dy),
    .dv_dy      (dv_dy),
    .pipe_stb_o (pipe_stb_o),
    .pipe_ack_i (pipe_ack_i),
    .P_X        (P_X),
    .P_Y        (P_Y),
    .P_U        (P_U),
    .P_V        (P_V),
    .down_busy  (down_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int u;
    int v;
  } pt_t;

  pt_t expq[$];
  int  compared = 0;
  int  mismatched = 0;
  int  xfers, busy_cnt, done_cnt, done_cyc, last_xfer_cyc;
  bit  hold_valid = 1'b0;
  int  hx, hy, hu, hv;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected point stream straight from the affine definition:
  // U = trunc((u0 + j*du_dy + i*du_dx) mod 2^11) with FRAC-bit fixed point.
  task automatic build_model(input int w, input int h, input int xs, input int ys,
                             input int us, input int vs, input int dudx, input int dvdx,
                             input int dudy, input int dvdy);
    int mask;
    mask = (1 << AW) - 1;
    expq.delete();
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        pt_t p;
        p.x = (xs + i) % 2048;
        p.y = (ys + j) % 2048;
        p.u = (((us << F) + j * dudy + i * dudx) & mask) >> F;
        p.v = (((vs << F) + j * dvdy + i * dvdx) & mask) >> F;
        expq.push_back(p);
      end
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int xs, input int ys,
                         input int us, input int vs, input int dudx, input int dvdx,
                         input int dudy, input int dvdy);
    width  = 11'(w);
    height = 11'(h);
    x0     = 11'(xs);
    y0     = 11'(ys);
    u0     = 11'(us);
    v0     = 11'(vs);
    du_dx  = AW'(dudx);
    dv_dx  = AW'(dvdx);
    du_dy  = AW'(dudy);
    dv_dy  = AW'(dvdy);
  endtask

  // Single compare process: every transfer against the model, plus hold stability.
  task automatic monitor();
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (hold_valid && pipe_stb_o) begin
          compared++;
          if (P_X != hx || P_Y != hy || P_U != hu || P_V != hv) begin
            mismatched++;
            $display("FAIL hold_stable: got X=%0d Y=%0d U=%0d V=%0d required X=%0d Y=%0d U=%0d V=%0d",
                     P_X, P_Y, P_U, P_V, hx, hy, hu, hv);
          end
        end
        hold_valid = pipe_stb_o && !pipe_ack_i;
        hx = P_X; hy = P_Y; hu = P_U; hv = P_V;
        if (pipe_stb_o && pipe_ack_i) begin
          compared++;
          if (expq.size() == 0) begin
            mismatched++;
            $display("FAIL extra_point: got X=%0d Y=%0d U=%0d V=%0d required no point",
                     P_X, P_Y, P_U, P_V);
          end else begin
            pt_t e;
            e = expq.pop_front();
            if (P_X != e.x || P_Y != e.y || P_U != e.u || P_V != e.v) begin
              mismatched++;
              $display("FAIL point%0d: got X=%0d Y=%0d U=%0d V=%0d required X=%0d Y=%0d U=%0d V=%0d",
                       xfers, P_X, P_Y, P_U, P_V, e.x, e.y, e.u, e.v);
            end
          end
          $display("xfer %0d: X=%0d Y=%0d U=%0d V=%0d", xfers, P_X, P_Y, P_U, P_V);
          xfers++;
          last_xfer_cyc = cyc;
        end
      end
    end
  endtask

  task automatic run_job(input string tag, input int w, input int h, input int xs, input int ys,
                         input int us, input int vs, input int dudx, input int dvdx,
                         input int dudy, input int dvdy, input int ack_mode,
                         input int abort_after, input int db_hold,
                         input int exp_xfers, input int exp_busy);
    int cycles;
    int fall_cyc;
    int db_left;
    bit aborted;
    set_cfg(w, h, xs, ys, us, vs, dudx, dvdx, dudy, dvdy);
    build_model(w, h, xs, ys, us, vs, dudx, dvdx, dudy, dvdy);
    @(posedge sys_clk); #1;
    start = 1'b1;
    pipe_ack_i = 1'b1;
    down_busy = (db_hold > 0);
    xfers = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_xfer_cyc = cyc;
    fall_cyc = -1; db_left = db_hold; aborted = 1'b0;
    @(posedge sys_clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_stb_after_start"}, pipe_stb_o, (w != 0 && h != 0) ? 1 : 0);
    if (w != 0 && h != 0) begin
      chk({tag, "_first_x"}, P_X, xs);
      chk({tag, "_first_u"}, P_U, us);
    end
    cycles = 0;
    while (done_cnt == 0 && cycles < 400) begin
      pipe_ack_i = (ack_mode == 0) ? 1'b1 : ((cycles % 2) == 0);
      if (abort_after >= 0 && !aborted && xfers == abort_after) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      @(posedge sys_clk); #1;
      if (abort) begin
        abort = 1'b0;
        expq.delete();
        chk({tag, "_stb_after_abort"}, pipe_stb_o, 0);
      end
      if (aborted && down_busy) begin
        if (db_left > 0) db_left--;
        if (db_left == 0) begin
          down_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
      cycles++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_busy_falls"}, busy, 0);
    chk({tag, "_done_single"}, done, 0);
    chk({tag, "_xfer_count"}, xfers, exp_xfers);
    chk({tag, "_model_drained"}, expq.size(), 0);
    if (db_hold > 0) chk({tag, "_done_after_down_busy"}, done_cyc, fall_cyc + 1);
    else             chk({tag, "_done_latency"}, done_cyc - last_xfer_cyc, 2);
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    $display("job %s: %0d points, done at cycle %0d", tag, xfers, done_cyc);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_stb", pipe_stb_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_px", P_X, 0);
    chk("rst_py", P_Y, 0);
    chk("rst_pu", P_U, 0);
    chk("rst_pv", P_V, 0);
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    // Pin the model against hand-computed points
    build_model(3, 2, 10, 20, 5, 7, 64, 64, 64, 64);
    chk("model_p3_x", expq[3].x, 10);
    chk("model_p3_y", expq[3].y, 21);
    chk("model_p5_u", expq[5].u, 8);
    chk("model_p5_v", expq[5].v, 10);
    build_model(4, 1, 0, 0, 0, 3, -32, 64, 0, 0);
    chk("model_wrap_u1", expq[1].u, 2047);
    chk("model_wrap_u2", expq[2].u, 2047);
    chk("model_wrap_u3", expq[3].u, 2046);

    run_job("basic", 3, 2, 10, 20, 5, 7, 64, 64, 64, 64, 0, -1, 0, 6, 8);
    run_job("toggle", 3, 2, 10, 20, 5, 7, 64, 64, 64, 64, 1, -1, 0, 6, -1);
    run_job("empty", 0, 5, 10, 20, 5, 7, 64, 64, 64, 64, 0, -1, 0, 0, 2);
    run_job("uwrap", 4, 1, 0, 0, 0, 3, -32, 64, 0, 0, 0, -1, 0, 4, 6);
    run_job("xywrap", 3, 2, 2046, 2047, 2040, 10, 100, -100, -200, 200, 0, -1, 0, 6, 8);
    run_job("abort", 4, 4, 30, 40, 1, 2, 64, 32, 128, -64, 0, 2, 5, 3, -1);

    // Asynchronous reset in the middle of a job
    set_cfg(4, 4, 100, 200, 9, 9, 64, 64, 64, 64);
    build_model(4, 4, 100, 200, 9, 9, 64, 64, 64, 64);
    xfers = 0;
    @(posedge sys_clk); #1;
    start = 1'b1;
    pipe_ack_i = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("midrst_stb", pipe_stb_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_xfers", xfers, 3);
    expq.delete();
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    run_job("after_rst", 3, 2, 10, 20, 5, 7, 64, 64, 64, 64, 0, -1, 0, 6, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
